// File: rtl/p4_stub_pkg.sv
// Shared types and default constants for the P4 stub match-action pipeline.
// stage_t describes one pipeline beat at the default widths.
package p4_stub_pkg;

  localparam int P4_DATA_W   = 512;
  localparam int P4_META_W   = 48;
  localparam int P4_LATENCY  = 4;
  localparam int P4_DROP_BIT = 0;
  localparam int P4_CNT_W    = 32;

  typedef struct packed {
    logic [P4_DATA_W-1:0]   data;
    logic [P4_DATA_W/8-1:0] keep;
    logic                   last;
    logic [P4_META_W-1:0]   meta;
  } stage_t;

endpackage

// File: rtl/p4_stub_stage.sv
// One elastic pipeline register stage: it loads when empty or when the next
// stage accepts in the same cycle, otherwise it holds its beat.
module p4_stub_stage
  import p4_stub_pkg::*;
#(
  parameter type T = stage_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  T     data_i,
  input  logic ready_i,
  output logic valid_o,
  output T     data_o
);

  logic valid_q, valid_d;
  T     data_q, data_d;
  logic load;

  assign load = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Payload needs no reset; it is always qualified by valid_q.
  always_ff @(posedge clk_i) data_q <= data_d;

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/p4_stub_pipeline.sv
// AXI-stream stub pipeline: per-packet metadata capture, optional drop on a
// metadata bit, a LATENCY-deep elastic register pipe and saturating counters.
module p4_stub_pipeline
  import p4_stub_pkg::*;
#(
  parameter int DATA_W   = P4_DATA_W,
  parameter int META_W   = P4_META_W,
  parameter int LATENCY  = P4_LATENCY,
  parameter int DROP_BIT = P4_DROP_BIT,
  parameter int CNT_W    = P4_CNT_W
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [META_W-1:0]   user_metadata_in,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [META_W-1:0]   user_metadata_out,
  output logic                user_metadata_out_valid,
  input  logic                drop_en,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    pkt_in_cnt,
  output logic [CNT_W-1:0]    pkt_drop_cnt,
  output logic [CNT_W-1:0]    pkt_out_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic                last;
    logic [META_W-1:0]   meta;
  } beat_t;

  logic              first_q, first_d;
  logic [META_W-1:0] pkt_meta_q, pkt_meta_d;
  logic              pkt_drop_q, pkt_drop_d;
  logic [META_W-1:0] meta_out_q, meta_out_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, drop_cnt_q, drop_cnt_d, out_cnt_q, out_cnt_d;

  logic [LATENCY:0]  vchain;
  logic [LATENCY:0]  rdy;
  beat_t             dchain [LATENCY+1];

  logic              cur_drop;
  logic [META_W-1:0] cur_meta;
  logic              in_hs, out_hs;

  // The first beat decides metadata and drop on the fly; later beats reuse the latched copy.
  assign cur_meta = first_q ? user_metadata_in : pkt_meta_q;
  assign cur_drop = first_q ? (drop_en && user_metadata_in[DROP_BIT]) : pkt_drop_q;

  assign s_axis_tready = !areset && (cur_drop || rdy[0]);
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  assign vchain[0] = s_axis_tvalid && !cur_drop && !areset;
  assign dchain[0] = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast, meta: cur_meta};

  always_comb begin
    logic acc;
    acc          = m_axis_tready && !areset;
    rdy[LATENCY] = acc;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      acc    = !vchain[i+1] || acc;
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    p4_stub_stage #(.T(beat_t)) u_stage (
      .clk_i   (aclk),
      .rst_i   (areset),
      .valid_i (vchain[i]),
      .data_i  (dchain[i]),
      .ready_i (rdy[i+1]),
      .valid_o (vchain[i+1]),
      .data_o  (dchain[i+1])
    );
  end

  assign m_axis_tvalid           = vchain[LATENCY] && !areset;
  assign m_axis_tdata            = dchain[LATENCY].data;
  assign m_axis_tkeep            = dchain[LATENCY].keep;
  assign m_axis_tlast            = dchain[LATENCY].last;
  assign out_hs                  = m_axis_tvalid && m_axis_tready;
  assign user_metadata_out_valid = out_hs && m_axis_tlast;
  assign user_metadata_out       = user_metadata_out_valid ? dchain[LATENCY].meta : meta_out_q;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic inc,
                                                 input logic clr);
    if (clr)              return '0;
    else if (inc && !(&cnt)) return cnt + CNT_W'(1);
    else                  return cnt;
  endfunction

  always_comb begin
    first_d    = first_q;
    pkt_meta_d = pkt_meta_q;
    pkt_drop_d = pkt_drop_q;
    meta_out_d = meta_out_q;
    if (in_hs) begin
      first_d = s_axis_tlast;
      if (first_q) begin
        pkt_meta_d = user_metadata_in;
        pkt_drop_d = cur_drop;
      end
    end
    if (user_metadata_out_valid) meta_out_d = dchain[LATENCY].meta;
    in_cnt_d   = cnt_next(in_cnt_q, in_hs && s_axis_tlast, cnt_clear);
    drop_cnt_d = cnt_next(drop_cnt_q, in_hs && s_axis_tlast && cur_drop, cnt_clear);
    out_cnt_d  = cnt_next(out_cnt_q, out_hs && m_axis_tlast, cnt_clear);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      first_q    <= 1'b1;
      pkt_meta_q <= '0;
      pkt_drop_q <= 1'b0;
      meta_out_q <= '0;
      in_cnt_q   <= '0;
      drop_cnt_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      first_q    <= first_d;
      pkt_meta_q <= pkt_meta_d;
      pkt_drop_q <= pkt_drop_d;
      meta_out_q <= meta_out_d;
      in_cnt_q   <= in_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign pkt_in_cnt   = in_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign pkt_out_cnt  = out_cnt_q;

endmodule
